morphle_cfg_loader: RTL and testbench
=====================================

Name: morphle_cfg_loader

Overview:
- Sequencer that shifts a configuration bitstream into one serial chain of Morphle Logic yellow cells.
- Each cell holds 3 config bits and passes them cell-to-cell on every confclk strobe.
- The block accepts configuration words from a host over a valid/ready handshake and serialises them MSB-first onto cbitin with generated confclk strobes.
- It holds the array in reset while loading and releases it after the load completes.

Parameters:
- CHAIN_LEN, 16, number of cells in the chain; total bits TOTAL = 3*CHAIN_LEN.
- WORD_W, 8, width of host configuration words.
- DIV, 2, clk cycles per confclk phase (low and high); must be at least 1.
- RST_CYC, 4, clk cycles array_reset is held before the first shift.

Ports:
- clk  in  1  block clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  begin a load; sampled only in IDLE.
- cfg_data  in  WORD_W  configuration word; bit WORD_W-1 is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts a word this cycle.
- array_reset  out  1  drives reset of every cell in the chain.
- confclk  out  1  configuration strobe to the chain.
- cbitin  out  1  serial bit to the first cell.
- cbitout  in  1  serial bit from the last cell.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes.
- rb_bit  out  1  readback bit (optional feature).
- rb_valid  out  1  readback strobe (optional feature).

Behaviour:
- Reset values: state IDLE; array_reset=1, confclk=0, cbitin=0, cfg_ready=0, busy=0, done=0, rb_bit=0, rb_valid=0; bit and word counters 0.
- All outputs are registered; no combinational input-to-output path.
- States: IDLE, RHOLD, FETCH, LOW, HIGH, SETTLE, FIN.
- IDLE:
  - array_reset keeps its last value: 1 after reset, 0 after a completed load.
  - start=1 → RHOLD, busy=1, array_reset=1.
  - cfg_valid is ignored.
- RHOLD: counts RST_CYC cycles, then → FETCH.
- FETCH:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready the word loads into the shift register; cfg_ready drops the next cycle; → LOW.
  - Waits indefinitely for cfg_valid.
- LOW:
  - cbitin = current MSB, confclk=0 for DIV cycles; → HIGH.
- HIGH:
  - confclk=1 for DIV cycles; cbitin held stable.
  - At the end, bit counter increments and the word register shifts left.
  - If bit counter == TOTAL → SETTLE.
  - Else if all WORD_W bits of the word are used → FETCH.
  - Else → LOW.
- Partial final word: when TOTAL is not a multiple of WORD_W, the unused low bits of the last word are discarded. Exactly ceil(TOTAL/WORD_W) words are accepted.
- SETTLE: confclk=0, cbitin=0 for 2 cycles; → FIN.
- FIN:
  - done=1 for one cycle, array_reset=0, busy=0; → IDLE.
- Stream ordering: the first 3 bits shifted end in the last cell, the first of them landing in that cell's config msb. The host supplies the farthest cell first.
- Exact strobes: exactly TOTAL confclk rising edges per load. cbitin changes only while confclk=0.
- start while busy is ignored.
- Asynchronous reset mid-load: immediately returns to IDLE with the reset values above; array_reset=1; partially shifted chain contents are undefined; any in-flight host word is dropped.
- Load duration after the last word is accepted: 2*DIV clk cycles per remaining bit + 3 cycles.

Optional Feature:
- Macro CFG_READBACK_EN.
- When defined:
  - In every HIGH entry cycle (rising confclk), cbitout is sampled onto rb_bit and rb_valid pulses for one cycle.
  - The TOTAL samples of a load are the previous chain configuration, oldest-last-cell bit first, so a host can read back the old config while writing the new one.
- When not defined: rb_bit and rb_valid are tied to 0 and no sampling logic exists.

Test Plan:
- Basic load (CHAIN_LEN=2, WORD_W=8, DIV=1): start, one word 8'b10111011 → cbitin sequence 1,0,1,1,1,0 on 6 confclk rises; 1 word accepted; done pulse; array_reset falls with done.
- Multi-word load (CHAIN_LEN=16 → TOTAL=48, WORD_W=8): host delays cfg_valid 5 cycles before each word → exactly 6 words accepted, 48 confclk rises, no confclk activity while in FETCH.
- Partial last word (CHAIN_LEN=3 → TOTAL=9, WORD_W=8): words 8'hFF then 8'h80 → 9 rises, 2 words accepted, last 7 bits discarded, cbitin all 1.
- Reset mid-load: assert reset after the 10th confclk rise → same cycle array_reset=1, confclk=0, busy=0, cfg_ready=0; a new start then completes a full TOTAL-bit load.
- start while busy, and cfg_valid in IDLE → both ignored; confclk rise count unchanged and cfg_ready stays 0 in IDLE.
- With CFG_READBACK_EN: model the chain as a 3*CHAIN_LEN shift register, load pattern A then pattern B → rb_bit stream during the second load equals A in shift-out order, with rb_valid pulsing exactly TOTAL times.

Source files
------------

// File: rtl/morphle_cfg_loader.sv
// morphle_cfg_loader: shifts a host-supplied bitstream MSB-first into a Morphle yellow-cell config chain
// Ports: clk/reset (async, active-high); start begins a load from IDLE;
//        cfg_data/cfg_valid/cfg_ready host word handshake; array_reset, confclk, cbitin drive the chain;
//        cbitout returns from the last cell; busy/done report load status; rb_bit/rb_valid readback.
// Macro CFG_READBACK_EN enables sampling of cbitout on every rising confclk.
module morphle_cfg_loader #(
   parameter int CHAIN_LEN = 16,
   parameter int WORD_W    = 8,
   parameter int DIV       = 2,
   parameter int RST_CYC   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              array_reset,
   output logic              confclk,
   output logic              cbitin,
   input  logic              cbitout,
   output logic              busy,
   output logic              done,
   output logic              rb_bit,
   output logic              rb_valid
);
   localparam int TOTAL = 3 * CHAIN_LEN;
   localparam int MC0   = DIV > RST_CYC ? DIV : RST_CYC;
   localparam int MC    = MC0 > 2 ? MC0 : 2;
   localparam int CW    = $clog2(MC + 1);
   localparam int BW    = $clog2(TOTAL + 1);
   localparam int WW    = $clog2(WORD_W + 1);
   typedef enum logic [2:0] {IDLE, RHOLD, FETCH, LOW, HIGH, SETTLE, FIN} state_t;
   state_t            state_q, state_d;
   logic [CW-1:0]     cyc_q, cyc_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [WW-1:0]     wbit_q, wbit_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              array_reset_q, confclk_q, cbitin_q, cfg_ready_q, busy_q, done_q;
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      wbit_d  = wbit_q;
      word_d  = word_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = RHOLD;
            cyc_d   = '0;
            bit_d   = '0;
         end
         RHOLD: if (cyc_q == CW'(RST_CYC - 1)) begin
            state_d = FETCH;
            cyc_d   = '0;
         end else cyc_d = cyc_q + 1'b1;
         FETCH: if (cfg_valid && cfg_ready_q) begin
            state_d = LOW;
            word_d  = cfg_data;
            wbit_d  = '0;
         end
         LOW: if (cyc_q == CW'(DIV - 1)) begin
            state_d = HIGH;
            cyc_d   = '0;
         end else cyc_d = cyc_q + 1'b1;
         HIGH: if (cyc_q == CW'(DIV - 1)) begin
            cyc_d   = '0;
            bit_d   = bit_q + 1'b1;
            wbit_d  = wbit_q + 1'b1;
            word_d  = word_q << 1;
            // the bit total wins over the word boundary, so unused low bits of a partial last word are dropped
            state_d = (bit_q == BW'(TOTAL - 1)) ? SETTLE : (wbit_q == WW'(WORD_W - 1)) ? FETCH : LOW;
         end else cyc_d = cyc_q + 1'b1;
         SETTLE: if (cyc_q == CW'(1)) begin
            state_d = FIN;
            cyc_d   = '0;
         end else cyc_d = cyc_q + 1'b1;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // outputs are registered from the next state so each one lines up with the state it belongs to
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cyc_q         <= '0;
         bit_q         <= '0;
         wbit_q        <= '0;
         word_q        <= '0;
         array_reset_q <= 1'b1;
         confclk_q     <= 1'b0;
         cbitin_q      <= 1'b0;
         cfg_ready_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cyc_q         <= cyc_d;
         bit_q         <= bit_d;
         wbit_q        <= wbit_d;
         word_q        <= word_d;
         array_reset_q <= (state_d == FIN) ? 1'b0 : (state_d == RHOLD) ? 1'b1 : array_reset_q;
         confclk_q     <= state_d == HIGH;
         cbitin_q      <= (state_d == LOW) ? word_d[WORD_W-1] : (state_d == HIGH) ? cbitin_q : 1'b0;
         cfg_ready_q   <= state_d == FETCH;
         busy_q        <= !(state_d inside {IDLE, FIN});
         done_q        <= state_d == FIN;
      end
   end
   assign array_reset = array_reset_q;
   assign confclk     = confclk_q;
   assign cbitin      = cbitin_q;
   assign cfg_ready   = cfg_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
`ifdef CFG_READBACK_EN
   logic rb_bit_q, rb_valid_q, rise;
   // cbitout is taken just before the chain shifts, so it is still the old last-cell bit
   assign rise = (state_d == HIGH) && (state_q != HIGH);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rb_bit_q   <= 1'b0;
         rb_valid_q <= 1'b0;
      end else begin
         rb_bit_q   <= rise ? cbitout : rb_bit_q;
         rb_valid_q <= rise;
      end
   end
   assign rb_bit   = rb_bit_q;
   assign rb_valid = rb_valid_q;
`else
   logic unused_cbitout;
   assign unused_cbitout = cbitout;
   assign rb_bit         = 1'b0;
   assign rb_valid       = 1'b0;
`endif
endmodule

// File: tb/tb_morphle_cfg_loader.sv
// tb_morphle_cfg_loader: directed bench for morphle_cfg_loader with a shift-register model of the chain
module tb_morphle_cfg_loader;
   localparam int TOT = 45;
   localparam int NW  = 6;
   logic       clk = 0, reset = 1, start = 0, cfg_valid = 0, cbitout;
   logic [7:0] cfg_data = 0;
   logic       cfg_ready, array_reset, confclk, cbitin, busy, done, rb_bit, rb_valid;
   int         n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   morphle_cfg_loader #(.CHAIN_LEN(15), .WORD_W(8), .DIV(2), .RST_CYC(4)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .array_reset(array_reset), .confclk(confclk), .cbitin(cbitin),
      .cbitout(cbitout), .busy(busy), .done(done), .rb_bit(rb_bit), .rb_valid(rb_valid)
   );
   logic [TOT-1:0] chain;
   always @(posedge confclk) chain <= {chain[TOT-2:0], cbitin};
   assign cbitout = chain[TOT-1];
   int          rises, words, dones, fviol, cviol, dur, last_dur, rbn, rdy;
   logic        pcc = 0, pcb = 0, dur_on, ar_done, clr = 0;
   logic [63:0] stream, rbs;
   always @(negedge clk) begin
      if (clr) begin
         rises <= 0; words <= 0; dones <= 0; fviol <= 0; cviol <= 0; dur <= 0;
         last_dur <= 0; rbn <= 0; rdy <= 0; dur_on <= 0; ar_done <= 1; stream <= 0; rbs <= 0;
      end else begin
         if (confclk && !pcc) begin
            rises  <= rises + 1;
            stream <= {stream[62:0], cbitin};
         end
         if (confclk && cfg_ready) fviol <= fviol + 1;
         if (confclk && cbitin != pcb) cviol <= cviol + 1;
         if (cfg_ready) rdy <= rdy + 1;
         if (cfg_valid && cfg_ready) begin
            words  <= words + 1;
            dur    <= 0;
            dur_on <= 1;
         end else if (dur_on) dur <= dur + 1;
         if (done) begin
            dones    <= dones + 1;
            last_dur <= dur + 1;
            dur_on   <= 0;
            ar_done  <= array_reset;
         end
         if (rb_valid) begin
            rbn <= rbn + 1;
            rbs <= {rbs[62:0], rb_bit};
         end
      end
      pcc <= confclk;
      pcb <= cbitin;
   end
   logic [7:0]     wa[NW], wb[NW], cur[NW];
   logic [47:0]    ca, cb;
   logic [TOT-1:0] exp_a, exp_b;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clear();
      tick();
      clr = 1;
      tick();
      clr = 0;
   endtask
   task automatic pulse_start();
      tick();
      start = 1;
      tick();
      start = 0;
   endtask
   task automatic feed(input logic [7:0] w, input int dly);
      int t = 0;
      while (!cfg_ready && t < 500) begin
         tick();
         t++;
      end
      chk("ready_wait", 64'(t < 500), 1);
      repeat (dly) tick();
      cfg_data  = w;
      cfg_valid = 1;
      tick();
      cfg_valid = 0;
   endtask
   task automatic run(input int dly, input bit poke);
      int t = 0;
      pulse_start();
      for (int i = 0; i < NW; i++) begin
         feed(cur[i], dly);
         if (poke && i == 2) pulse_start();
      end
      while (!done && t < 2000) begin
         tick();
         t++;
      end
      chk("done_wait", 64'(t < 2000), 1);
      repeat (2) tick();
   endtask
   initial begin
      int t;
      wa = '{8'hBB, 8'h12, 8'h34, 8'hC5, 8'h6E, 8'hF7};
      wb = '{8'h5A, 8'hC3, 8'h0F, 8'h99, 8'hE1, 8'h28};
      ca = {wa[0], wa[1], wa[2], wa[3], wa[4], wa[5]};
      cb = {wb[0], wb[1], wb[2], wb[3], wb[4], wb[5]};
      exp_a = ca[47:3];
      exp_b = cb[47:3];
      repeat (3) tick();
      chk("rst_array_reset", 64'(array_reset), 1);
      chk("rst_confclk", 64'(confclk), 0);
      chk("rst_cbitin", 64'(cbitin), 0);
      chk("rst_cfg_ready", 64'(cfg_ready), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_rb", 64'({rb_bit, rb_valid}), 0);
      reset = 0;
      clear();
      cur = wa;
      run(5, 0);
      chk("a_rises", 64'(rises), TOT);
      chk("a_words", 64'(words), NW);
      chk("a_dones", 64'(dones), 1);
      chk("a_first6", 64'(stream[44:39]), 64'b101110);
      chk("a_partial", 64'(stream[4:0]), 64'b11110);
      chk("a_stream", 64'(stream[TOT-1:0]), 64'(exp_a));
      chk("a_chain", 64'(chain), 64'(exp_a));
      chk("a_fetch_cc", 64'(fviol), 0);
      chk("a_cbit_stable", 64'(cviol), 0);
      chk("a_tail_len", 64'(last_dur), 23);
      chk("a_ar_at_done", 64'(ar_done), 0);
      chk("a_ar_after", 64'(array_reset), 0);
      chk("a_busy_after", 64'(busy), 0);
      clear();
      cur = wb;
      run(0, 1);
      chk("b_rises", 64'(rises), TOT);
      chk("b_words", 64'(words), NW);
      chk("b_dones", 64'(dones), 1);
      chk("b_stream", 64'(stream[TOT-1:0]), 64'(exp_b));
      chk("b_cbit_stable", 64'(cviol), 0);
`ifdef CFG_READBACK_EN
      chk("b_rb_count", 64'(rbn), TOT);
      chk("b_rb_stream", 64'(rbs[TOT-1:0]), 64'(exp_a));
`else
      chk("b_rb_count", 64'(rbn), 0);
`endif
      clear();
      cfg_data  = 8'hAA;
      cfg_valid = 1;
      repeat (10) tick();
      cfg_valid = 0;
      tick();
      chk("idle_ready", 64'(rdy), 0);
      chk("idle_words", 64'(words), 0);
      chk("idle_rises", 64'(rises), 0);
      chk("idle_busy", 64'(busy), 0);
      clear();
      cur = wa;
      pulse_start();
      feed(cur[0], 0);
      feed(cur[1], 0);
      t = 0;
      while (rises < 10 && t < 500) begin
         tick();
         t++;
      end
      chk("mid_rises", 64'(rises), 10);
      chk("mid_cc_high", 64'(confclk), 1);
      #2 reset = 1;
      #1;
      chk("mid_array_reset", 64'(array_reset), 1);
      chk("mid_confclk", 64'(confclk), 0);
      chk("mid_busy", 64'(busy), 0);
      chk("mid_cfg_ready", 64'(cfg_ready), 0);
      tick();
      reset = 0;
      clear();
      run(0, 0);
      chk("r_rises", 64'(rises), TOT);
      chk("r_words", 64'(words), NW);
      chk("r_dones", 64'(dones), 1);
      chk("r_stream", 64'(stream[TOT-1:0]), 64'(exp_a));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
